// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit holding the HI/LO registers.
// One operation per accepted start: 32 shift-add / restoring-divide steps, then a sign-fix cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state_q, state_d;
   logic [4:0]         count_q, count_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opd_q, opd_d;
   logic [WIDTH-1:0]   in1_q, in1_d;
   logic               is_div_q, is_div_d;
   logic               qsign_q, qsign_d;
   logic               rsign_q, rsign_d;
   logic               dz_q, dz_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               is_signed;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   always_comb begin
      is_signed = ~op[0];
      a_abs     = (is_signed && in1[WIDTH-1]) ? -in1 : in1;
      b_abs     = (is_signed && in2[WIDTH-1]) ? -in2 : in2;

      // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};

      // Divide: {remainder, dividend} shifts left; quotient bits enter at the bottom.
      rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff = rem_sh - {1'b0, opd_q};
      div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

      prod_fix = qsign_q ? -acc_q : acc_q;
      quo_fix  = qsign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      acc_d    = acc_q;
      opd_d    = opd_q;
      in1_d    = in1_q;
      is_div_d = is_div_q;
      qsign_d  = qsign_q;
      rsign_d  = rsign_q;
      dz_d     = dz_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         IDLE: begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
            if (start) begin
               state_d  = CALC;
               count_d  = '0;
               busy_d   = 1'b1;
               is_div_d = op[1];
               acc_d    = op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
               opd_d    = op[1] ? b_abs : a_abs;
               in1_d    = in1;
               qsign_d  = is_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
               rsign_d  = is_signed & in1[WIDTH-1];
               dz_d     = op[1] && (in2 == '0);
            end
         end
         CALC: begin
            acc_d   = is_div_q ? div_next : mul_next;
            count_d = count_q + 5'd1;
            if (count_q == 5'd31) state_d = FIX;
         end
         FIX: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (!is_div_q) begin
               {hi_d, lo_d} = prod_fix;
            end else if (dz_q) begin
               hi_d = in1_q;
               lo_d = '1;
            end else begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         acc_q    <= '0;
         opd_q    <= '0;
         in1_q    <= '0;
         is_div_q <= 1'b0;
         qsign_q  <= 1'b0;
         rsign_q  <= 1'b0;
         dz_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         acc_q    <= acc_d;
         opd_q    <= opd_d;
         in1_q    <= in1_d;
         is_div_q <= is_div_d;
         qsign_q  <= qsign_d;
         rsign_q  <= rsign_d;
         dz_q     <= dz_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed HI/LO results, busy/done timing,
// ignored requests while busy, idle direct writes and asynchronous reset.
module tb_muldiv_unit;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] in1;
   logic [31:0] in2;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .in1     (in1),
      .in2     (in2),
      .hi_we   (hi_we),
      .lo_we   (lo_we),
      .wdata   (wdata),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called just after a clock edge; returns #1 after the edge that ends the op (done visible).
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el,
                         input string tag, input bit poke);
      int busy_cnt;
      start = 1'b1;
      op    = o;
      in1   = a;
      in2   = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      in1   = $urandom;
      in2   = $urandom;
      op    = 2'($urandom_range(0, 3));
      busy_cnt = busy ? 1 : 0;
      chk({tag, "_accept"}, {62'd0, busy, done}, 64'b10);
      for (int k = 1; k <= 33; k++) begin
         if (poke && k == 5) begin
            hi_we = 1'b1;
            wdata = 32'h0000_1234;
         end
         if (poke && k == 10) begin
            start = 1'b1;
            op    = 2'b00;
            in1   = 32'd3;
            in2   = 32'd3;
         end
         @(posedge clk);
         #1;
         hi_we = 1'b0;
         start = 1'b0;
         if (busy) busy_cnt++;
         if (k < 33) begin
            chk({tag, "_mid_flags"}, {62'd0, busy, done}, 64'b10);
            chk({tag, "_mid_hilo"}, {hi, lo}, {m_hi, m_lo});
         end
      end
      chk({tag, "_done_flags"}, {62'd0, busy, done}, 64'b01);
      chk({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
      chk({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
      chk({tag, "_busy_len"}, 64'(busy_cnt), 64'd33);
      m_hi = eh;
      m_lo = el;
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      op      = 2'b00;
      in1     = '0;
      in2     = '0;
      hi_we   = 1'b0;
      lo_we   = 1'b0;
      wdata   = '0;
      #1;
      chk("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 1'b0);
      run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg", 1'b0);
      run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg", 1'b0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf", 1'b0);
      run_op(2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, "divu_dz", 1'b0);
      run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_dz", 1'b0);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min", 1'b0);
      run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu_poke", 1'b1);

      // Idle direct writes, issued in the done cycle so they land on the next edge.
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'hA5A5_A5A5;
      @(posedge clk);
      #1;
      hi_we = 1'b0;
      lo_we = 1'b0;
      m_hi  = 32'hA5A5_A5A5;
      m_lo  = 32'hA5A5_A5A5;
      chk("idle_wr_both", {hi, lo}, {m_hi, m_lo});
      hi_we = 1'b1;
      wdata = 32'h0000_0011;
      @(posedge clk);
      #1;
      hi_we = 1'b0;
      m_hi  = 32'h0000_0011;
      chk("idle_wr_hi", {hi, lo}, {m_hi, m_lo});

      // Reset mid-CALC: count reaches 12 after the twelfth CALC edge.
      start = 1'b1;
      op    = 2'b00;
      in1   = 32'd5;
      in2   = 32'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (12) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      m_hi = '0;
      m_lo = '0;
      chk("async_reset", {30'd0, busy, done, hi, lo}, 64'd0);
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_reset_idle", {30'd0, busy, done, hi, lo}, 64'd0);
      run_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, "multu_small", 1'b0);

      @(posedge clk);
      #1;
      chk("after_done", {62'd0, busy, done}, 64'b00);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
